branch_op: RTL and testbench
============================

BRANCH_OP -- requirements
Module: branch_op

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: opcode on this cycle is a real instruction.
REQ-004 SHALL have port opcode, input, 6 bits: MIPS primary opcode field (instr[31:26]).
REQ-005 SHALL have port out_valid, output, 1 bit: registered copy of in_valid.
REQ-006 SHALL have port is_branch, output, 6 bits: one-hot branch/jump class of the registered opcode.
REQ-007 SHALL have port override_rt, output, 1 bit: comparator second operand comes from rt_val instead of register rt.
REQ-008 SHALL have port rt_val, output, 32 bits: constant second comparator operand, meaningful when override_rt=1.
REQ-009 SHALL contain no parameters; all widths are fixed as listed.

Function
REQ-010 SHALL register all outputs: outputs reflect the opcode/in_valid sampled at the previous rising clk edge (latency exactly 1 cycle, throughput 1 per cycle).
REQ-011 SHALL decode is_branch as follows (bit = 1, all other bits 0):
- bit0: opcode 6'h04 (BEQ)
- bit1: opcode 6'h05 (BNE)
- bit2: opcode 6'h06 (BLEZ)
- bit3: opcode 6'h07 (BGTZ)
- bit4: opcode 6'h01 (REGIMM: BLTZ/BGEZ family)
- bit5: opcode 6'h02 (J) or 6'h03 (JAL)
REQ-012 SHALL drive is_branch = 6'b000000 for every other opcode (6'h00, 6'h08-6'h3F).
REQ-013 SHALL guarantee is_branch is zero or one-hot on every cycle; never more than one bit set.
REQ-014 SHALL drive override_rt = 1 for BLEZ, BGTZ and REGIMM (compare rs against zero); 0 otherwise.
REQ-015 SHALL drive rt_val = 32'h0000_0000 for all opcodes (the only override constant is zero).
REQ-016 SHALL, when in_valid = 0 at the sampling edge, register is_branch = 0, override_rt = 0, rt_val = 0, out_valid = 0 regardless of opcode.
REQ-017 SHALL treat opcode as fully decoded with no X-propagation: all 64 values produce defined outputs.
REQ-018 SHALL hold no state other than the output registers; back-to-back opcodes are independent.

Reset
REQ-019 SHALL, on rst_n low, asynchronously force out_valid = 0, is_branch = 6'b000000, override_rt = 0, rt_val = 32'h0 without waiting for clk.
REQ-020 SHALL keep outputs at reset values while rst_n is low; first decode appears on the first rising clk edge after rst_n deasserts.
REQ-021 SHALL discard any opcode sampled in the cycle rst_n asserts mid-operation; no stale output after reset release.

Verification
REQ-022 Sweep opcode 6'h00..6'h3F with in_valid=1, one per cycle -> one cycle later 6'h04->is_branch=6'b000001, 6'h05->000010, 6'h06->000100 override_rt=1, 6'h07->001000 override_rt=1, 6'h01->010000 override_rt=1, 6'h02/6'h03->100000 override_rt=0, all others 000000 override_rt=0; rt_val always 0.
REQ-023 opcode=6'h04, in_valid=0 -> next cycle out_valid=0, is_branch=0, override_rt=0.
REQ-024 Assert rst_n=0 between clk edges after opcode=6'h06 was registered -> outputs clear immediately, before next clk edge.
REQ-025 Back-to-back 6'h05 then 6'h07 then 6'h23 -> is_branch 000010, 001000, 000000 on consecutive cycles, override_rt 0,1,0.
REQ-026 Every cycle of every test -> $countones(is_branch) <= 1 and rt_val == 0.

Source files
------------

// File: rtl/branch_op_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_op_if
//  Description : Opcode-in / branch-class-out bundle for the branch decoder.
//                master = instruction source, slave = decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_op_if;
   logic        in_valid;
   logic [5:0]  opcode;
   logic        out_valid;
   logic [5:0]  is_branch;
   logic        override_rt;
   logic [31:0] rt_val;

   modport master (
      output in_valid,
      output opcode,
      input  out_valid,
      input  is_branch,
      input  override_rt,
      input  rt_val
   );

   modport slave (
      input  in_valid,
      input  opcode,
      output out_valid,
      output is_branch,
      output override_rt,
      output rt_val
   );
endinterface
`default_nettype wire

// File: rtl/branch_op.sv
`default_nettype none
// ============================================================================
//  Module      : branch_op
//  Description : Registered decoder of the MIPS primary opcode into a one-hot
//                branch/jump class plus the comparator second-operand override.
//                Fixed 1-cycle latency, 1 opcode per cycle, no other state.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_op (
   input  wire          clk,
   input  wire          rst_n,
   branch_op_if.slave   bus
);

   logic        out_valid_d,   out_valid_q;
   logic [5:0]  is_branch_d,   is_branch_q;
   logic        override_rt_d, override_rt_q;
   logic [31:0] rt_val_d,      rt_val_q;

   // Decode the incoming opcode; an invalid slot decodes to all-zero outputs.
   always_comb begin
      out_valid_d   = bus.in_valid;
      is_branch_d   = 6'b000000;
      override_rt_d = 1'b0;
      // Zero is the only constant operand any branch compares against.
      rt_val_d      = 32'h0000_0000;
      if (bus.in_valid) begin
         case (bus.opcode)
            6'h04: is_branch_d = 6'b000001;          // BEQ
            6'h05: is_branch_d = 6'b000010;          // BNE
            6'h06: begin                             // BLEZ: rs vs zero
               is_branch_d   = 6'b000100;
               override_rt_d = 1'b1;
            end
            6'h07: begin                             // BGTZ: rs vs zero
               is_branch_d   = 6'b001000;
               override_rt_d = 1'b1;
            end
            6'h01: begin                             // REGIMM: rs vs zero
               is_branch_d   = 6'b010000;
               override_rt_d = 1'b1;
            end
            6'h02,
            6'h03: is_branch_d = 6'b100000;          // J / JAL
            default: begin
               is_branch_d   = 6'b000000;
               override_rt_d = 1'b0;
            end
         endcase
      end
   end

   // Output registers; reset clears them immediately, independent of clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q   <= 1'b0;
         is_branch_q   <= 6'b000000;
         override_rt_q <= 1'b0;
         rt_val_q      <= 32'h0000_0000;
      end else begin
         out_valid_q   <= out_valid_d;
         is_branch_q   <= is_branch_d;
         override_rt_q <= override_rt_d;
         rt_val_q      <= rt_val_d;
      end
   end

   assign bus.out_valid   = out_valid_q;
   assign bus.is_branch   = is_branch_q;
   assign bus.override_rt = override_rt_q;
   assign bus.rt_val      = rt_val_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_op.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_op
//  Description : Directed self-checking bench for branch_op. Inputs change on
//                the falling edge, outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_op;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   logic mon_en;

   branch_op_if bus ();

   branch_op u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed observation: {out_valid, is_branch, override_rt, rt_val}
   function automatic logic [39:0] observed();
      return {bus.out_valid, bus.is_branch, bus.override_rt, bus.rt_val};
   endfunction

   // Hand-written decode table used for the full opcode sweep.
   function automatic logic [39:0] expected(input logic v, input logic [5:0] op);
      logic [5:0] b;
      logic       o;
      b = 6'b000000;
      o = 1'b0;
      if (v) begin
         case (op)
            6'h04: b = 6'b000001;
            6'h05: b = 6'b000010;
            6'h06: begin b = 6'b000100; o = 1'b1; end
            6'h07: begin b = 6'b001000; o = 1'b1; end
            6'h01: begin b = 6'b010000; o = 1'b1; end
            6'h02: b = 6'b100000;
            6'h03: b = 6'b100000;
            default: begin b = 6'b000000; o = 1'b0; end
         endcase
      end
      return {v, b, o, 32'h0000_0000};
   endfunction

   task automatic check(input string tag, input logic [39:0] exp);
      logic [39:0] obs;
      obs = observed();
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] op);
      bus.in_valid = v;
      bus.opcode   = op;
   endtask

   // Invariant on every sampled cycle: zero-or-one-hot class and rt_val zero.
   always @(negedge clk) begin
      if (mon_en) begin
         n_checks++;
         assert ($countones(bus.is_branch) <= 1 && bus.rt_val === 32'h0) else begin
            n_errors++;
            $error("FAIL invariant: is_branch=%b rt_val=%h required onehot0 and 0",
                   bus.is_branch, bus.rt_val);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      rst_n    = 1'b0;
      drive(1'b1, 6'h04);

      // Reset held across edges: outputs stay cleared despite a valid opcode.
      repeat (3) @(negedge clk);
      check("reset_state", 40'h0);
      mon_en = 1'b1;

      // Release reset; first decode on the next rising edge.
      rst_n = 1'b1;
      drive(1'b1, 6'h04);
      @(negedge clk);
      check("first_after_reset_beq", {1'b1, 6'b000001, 1'b0, 32'h0});

      // in_valid low masks the opcode completely.
      drive(1'b0, 6'h04);
      @(negedge clk);
      check("invalid_beq", 40'h0);
      drive(1'b0, 6'h07);
      @(negedge clk);
      check("invalid_bgtz", 40'h0);

      // Back-to-back pipelined stream: 05, 07, 23.
      drive(1'b1, 6'h05);
      @(negedge clk);
      check("b2b_bne", {1'b1, 6'b000010, 1'b0, 32'h0});
      drive(1'b1, 6'h07);
      @(negedge clk);
      check("b2b_bgtz", {1'b1, 6'b001000, 1'b1, 32'h0});
      drive(1'b1, 6'h23);
      @(negedge clk);
      check("b2b_lw", {1'b1, 6'b000000, 1'b0, 32'h0});

      // Full sweep, one opcode per cycle, checked one cycle later.
      for (int i = 0; i <= 64; i++) begin
         if (i < 64) drive(1'b1, 6'(i));
         else        drive(1'b0, 6'h00);
         @(negedge clk);
         if (i < 64) check($sformatf("sweep_op_%02h", i), expected(1'b1, 6'(i)));
      end
      check("sweep_tail_idle", 40'h0);

      // Asynchronous reset between edges after BLEZ was registered.
      drive(1'b1, 6'h06);
      @(negedge clk);
      check("blez_before_reset", {1'b1, 6'b000100, 1'b1, 32'h0});
      drive(1'b1, 6'h01);
      #2 rst_n = 1'b0;
      #1 check("async_reset_clears", 40'h0);

      // Opcode present while reset is low is discarded.
      @(negedge clk);
      check("reset_held_discard", 40'h0);

      // Release mid-stream; new decode appears after the next edge only.
      drive(1'b1, 6'h02);
      rst_n = 1'b1;
      #1 check("just_released_still_clear", 40'h0);
      @(negedge clk);
      check("post_reset_j", {1'b1, 6'b100000, 1'b0, 32'h0});
      drive(1'b1, 6'h01);
      @(negedge clk);
      check("post_reset_regimm", {1'b1, 6'b010000, 1'b1, 32'h0});
      drive(1'b0, 6'h01);
      @(negedge clk);
      check("final_idle", 40'h0);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
